// File: rtl/vape_exec_proof.sv
// ER execution-proof tracker: follows one ER run from entry to exit and holds a
// sticky proof bit while the run's output region and ER stay untouched.
module vape_exec_proof #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      pc,
  input  logic [15:0]      data_addr,
  input  logic             data_wr,
  input  logic [15:0]      dma_addr,
  input  logic             dma_en,
  input  logic             irq,
  input  logic             exec,
  input  logic [15:0]      ER_min,
  input  logic [15:0]      ER_max,
  input  logic [15:0]      OR_min,
  input  logic [15:0]      OR_max,
  output logic             proof,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] run_count,
  output logic [2:0]       fail_cause
);

  localparam int unsigned CAUSE_W = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] CAUSE_NO_EXEC  = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ      = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] CAUSE_DMA      = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] CAUSE_LEFT_ER  = CAUSE_W'(4);
  localparam logic [CAUSE_W-1:0] CAUSE_OR_WR    = CAUSE_W'(5);
  localparam logic [CAUSE_W-1:0] CAUSE_OR_DMA   = CAUSE_W'(6);
  localparam logic [CAUSE_W-1:0] CAUSE_ER_TAMP  = CAUSE_W'(7);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_FAIL = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 proof_q, proof_d;
  logic [CNT_W-1:0]     run_count_q, run_count_d;
  logic [CAUSE_W-1:0]   fail_cause_q, fail_cause_d;
  logic [CAUSE_W-1:0]   viol_cause_c;

  logic in_er_c, entry_c, wr_or_c, dma_or_c, wr_er_c;

  // Address-window qualifiers, all bounds inclusive.
  assign in_er_c  = (pc >= ER_min) && (pc <= ER_max);
  assign entry_c  = (pc == ER_min) && exec;
  assign wr_or_c  = data_wr && (data_addr >= OR_min) && (data_addr <= OR_max);
  assign dma_or_c = dma_en && (dma_addr >= OR_min) && (dma_addr <= OR_max);
  assign wr_er_c  = data_wr && (data_addr >= ER_min) && (data_addr <= ER_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      proof_q      <= 1'b0;
      run_count_q  <= '0;
      fail_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      proof_q      <= proof_d;
      run_count_q  <= run_count_d;
      fail_cause_q <= fail_cause_d;
    end
  end

  // Next state; violations are ranked so the first hit names the failure.
  always_comb begin
    state_d      = state_q;
    viol_cause_c = CAUSE_NONE;
    case (state_q)
      S_IDLE: begin
        if (entry_c) state_d = S_RUN;
      end
      S_RUN: begin
        if (!exec)         viol_cause_c = CAUSE_NO_EXEC;
        else if (irq)      viol_cause_c = CAUSE_IRQ;
        else if (dma_en)   viol_cause_c = CAUSE_DMA;
        else if (!in_er_c) viol_cause_c = CAUSE_LEFT_ER;

        if (viol_cause_c != CAUSE_NONE) state_d = S_FAIL;
        else if (pc == ER_max)          state_d = S_DONE;
      end
      S_DONE: begin
        if (wr_or_c && !in_er_c)   viol_cause_c = CAUSE_OR_WR;
        else if (dma_or_c)         viol_cause_c = CAUSE_OR_DMA;
        else if (wr_er_c || !exec) viol_cause_c = CAUSE_ER_TAMP;

        if (viol_cause_c != CAUSE_NONE) state_d = S_FAIL;
        else if (entry_c)               state_d = S_RUN;
      end
      S_FAIL: begin
        if (entry_c) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs track the state being entered, so proof rises with DONE.
  always_comb begin
    proof_d      = (state_d == S_DONE);
    run_count_d  = run_count_q;
    fail_cause_d = fail_cause_q;
    if ((state_q == S_RUN) && (state_d == S_DONE) && (run_count_q != CNT_MAX)) begin
      run_count_d = run_count_q + CNT_W'(1);
    end
    if (viol_cause_c != CAUSE_NONE) begin
      fail_cause_d = viol_cause_c;
    end
  end

  assign proof      = proof_q;
  assign state      = state_q;
  assign run_count  = run_count_q;
  assign fail_cause = fail_cause_q;

endmodule
